// File: rtl/seg7_display_driver.sv
// Signed 16-bit value -> sign + 3 BCD digits (sequential double-dabble), time-multiplexed onto a
// 4-digit active-low 7-segment display. Optional cursor blink when SEG7_BLINK_EN is defined.
module seg7_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic        value_valid,
   input  logic [1:0]  cursor_sel,
   input  logic        blink_on,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_R     = 7'b0101111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   function automatic logic [16:0] f_mag(input logic [15:0] v);
      logic [16:0] ext;
      ext = {v[15], v};
      return v[15] ? (~ext + 17'd1) : ext;
   endfunction

   function automatic logic [15:0] f_adj(input logic [15:0] b);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [6:0] f_digit(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // ---------------- conversion FSM ----------------
   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_load;
   logic [15:0] w_load_val;
   logic        w_commit;
   logic        w_pend_clr;

   logic [15:0] r_bin;
   logic [19:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_sign_work;
   logic        r_pend_vld;
   logic [15:0] r_pend_val;

   logic        r_disp_sign;
   logic        r_disp_ovf;
   logic [3:0]  r_disp_d0;
   logic [3:0]  r_disp_d1;
   logic [3:0]  r_disp_d2;

   logic [16:0] w_mag;
   logic [15:0] w_bcd_adj;

   assign w_mag     = f_mag(w_load_val);
   assign w_bcd_adj = f_adj(r_bcd[15:0]);
   assign busy      = (r_state != S_IDLE);
   assign dp        = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A strobe during COMMIT is the newest value, so it wins over the pending slot.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = value_in;
      w_commit    = 1'b0;
      w_pend_clr  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (value_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == 4'd15) begin
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_commit = 1'b1;
            if (value_valid) begin
               w_load      = 1'b1;
               w_pend_clr  = 1'b1;
               w_state_nxt = S_SHIFT;
            end else if (r_pend_vld) begin
               w_load      = 1'b1;
               w_load_val  = r_pend_val;
               w_pend_clr  = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_vld <= 1'b0;
         r_pend_val <= 16'd0;
      end else if (w_pend_clr) begin
         r_pend_vld <= 1'b0;
      end else if (value_valid && r_state == S_SHIFT) begin
         r_pend_vld <= 1'b1;
         r_pend_val <= value_in;
      end
   end

   // The magnitude MSB is pre-shifted at load so 17 bits convert in 16 shift cycles.
   // The top BCD nibble never exceeds 3, so it needs no add-3 correction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin       <= 16'd0;
         r_bcd       <= 20'd0;
         r_cnt       <= 4'd0;
         r_sign_work <= 1'b0;
      end else if (w_load) begin
         r_sign_work <= w_load_val[15];
         r_bcd       <= {19'd0, w_mag[16]};
         r_bin       <= w_mag[15:0];
         r_cnt       <= 4'd0;
      end else if (r_state == S_SHIFT) begin
         r_bcd <= {r_bcd[18:16], w_bcd_adj, r_bin[15]};
         r_bin <= {r_bin[14:0], 1'b0};
         r_cnt <= r_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp_sign <= 1'b0;
         r_disp_ovf  <= 1'b0;
         r_disp_d0   <= 4'd0;
         r_disp_d1   <= 4'd0;
         r_disp_d2   <= 4'd0;
      end else if (w_commit) begin
         r_disp_sign <= r_sign_work;
         r_disp_ovf  <= |r_bcd[19:12];
         r_disp_d0   <= r_bcd[3:0];
         r_disp_d1   <= r_bcd[7:4];
         r_disp_d2   <= r_bcd[11:8];
      end
   end

   // ---------------- scan ----------------
   logic [RW-1:0] r_div;
   logic [1:0]    r_slot;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          w_tick;
   logic          w_blank;
   logic [6:0]    w_glyph;

   assign w_tick = (r_div == REFRESH_LAST);
   assign an     = r_an;
   assign seg    = r_seg;

`ifdef SEG7_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_off;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink_off <= ~r_blink_off;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign w_blank = blink_on & r_blink_off & (r_slot == cursor_sel);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{cursor_sel, blink_on};
   assign w_blank      = 1'b0;
`endif

   always_comb begin
      w_glyph = GLYPH_BLANK;
      case (r_slot)
         2'd0: w_glyph = r_disp_ovf ? GLYPH_R : f_digit(r_disp_d0);
         2'd1: w_glyph = r_disp_ovf ? GLYPH_R : f_digit(r_disp_d1);
         2'd2: w_glyph = r_disp_ovf ? GLYPH_E : f_digit(r_disp_d2);
         2'd3: w_glyph = r_disp_sign ? GLYPH_DASH : GLYPH_BLANK;
         default: w_glyph = GLYPH_BLANK;
      endcase
      if (w_blank) begin
         w_glyph = GLYPH_BLANK;
      end
   end

   // r_slot names the slot the next tick will drive, so the first tick lights slot 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_slot <= 2'd0;
         r_an   <= 4'b1111;
         r_seg  <= GLYPH_BLANK;
      end else if (w_tick) begin
         r_div  <= '0;
         r_slot <= r_slot + 2'd1;
         r_an   <= ~(4'b0001 << r_slot);
         r_seg  <= w_glyph;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver: randomized and boundary values checked against
// an arithmetic display model; scan order, latency, pending-overwrite, reset and blink behaviour.
module tb_seg7_display_driver;

   localparam int RDIV = 4;
   localparam int BDIV = 16;

   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_R     = 7'b0101111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value_in = 16'd0;
   logic        value_valid = 1'b0;
   logic [1:0]  cursor_sel = 2'd0;
   logic        blink_on = 1'b0;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] dig_tab [10];

   seg7_display_driver #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
      .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
      .cursor_sel(cursor_sel), .blink_on(blink_on), .busy(busy),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   // Expected glyph on slot k for a displayed signed value.
   function automatic logic [6:0] exp_glyph(input int v, input int slot);
      int mag;
      mag = (v < 0) ? -v : v;
      if (slot == 3) return (v < 0) ? G_DASH : G_BLANK;
      if (mag > 999) return (slot == 2) ? G_E : G_R;
      if (slot == 0) return dig_tab[mag % 10];
      if (slot == 1) return dig_tab[(mag / 10) % 10];
      return dig_tab[mag / 100];
   endfunction

   function automatic int slot_of(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int v);
      value_in    = 16'(v);
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
   endtask

   // Called right after strobe(): counts busy-high samples until busy falls.
   task automatic wait_idle(input string name, input int exp_cycles);
      int cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         cnt++;
         tick();
      end
      n_tests++;
      if (cnt != exp_cycles) begin
         n_fail++;
         $display("FAIL %s busy_cycles got=%0d expected=%0d", name, cnt, exp_cycles);
      end
   endtask

   task automatic check_display(input string name, input int v);
      bit seen [4];
      int k;
      int prev;
      for (int i = 0; i < 4; i++) seen[i] = 1'b0;
      prev = -1;
      repeat (RDIV + 1) tick();
      for (int c = 0; c < 5 * RDIV; c++) begin
         tick();
         k = slot_of(an);
         n_tests++;
         if (k < 0) begin
            n_fail++;
            $display("FAIL %s an_onehot got=%b", name, an);
         end else begin
            if (prev >= 0 && k != prev) begin
               n_tests++;
               if (k != (prev + 1) % 4) begin
                  n_fail++;
                  $display("FAIL %s scan_order got=%0d expected=%0d", name, k, (prev + 1) % 4);
               end
            end
            prev = k;
            if (!seen[k]) begin
               seen[k] = 1'b1;
               n_tests++;
               if (seg !== exp_glyph(v, k)) begin
                  n_fail++;
                  $display("FAIL %s slot%0d seg got=%b expected=%b (value %0d)",
                           name, k, seg, exp_glyph(v, k), v);
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (!seen[i]) begin
            n_fail++;
            $display("FAIL %s slot%0d_visited got=0 expected=1", name, i);
         end
      end
      n_tests++;
      if (dp !== 1'b1) begin
         n_fail++;
         $display("FAIL %s dp got=%b expected=1", name, dp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (an !== 4'b1111 || seg !== G_BLANK || busy !== 1'b0 || dp !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs got an=%b seg=%b busy=%b dp=%b expected 1111 1111111 0 1",
                  an, seg, busy, dp);
      end
      reset = 1'b0;
      for (int i = 1; i < RDIV; i++) begin
         tick();
         n_tests++;
         if (an !== 4'b1111 || seg !== G_BLANK) begin
            n_fail++;
            $display("FAIL pre_tick cycle%0d got an=%b seg=%b expected 1111 1111111", i, an, seg);
         end
      end
      tick();
      n_tests++;
      if (an !== 4'b1110 || seg !== exp_glyph(0, 0)) begin
         n_fail++;
         $display("FAIL first_tick got an=%b seg=%b expected 1110 %b", an, seg, exp_glyph(0, 0));
      end
      check_display("reset_scan", 0);
   endtask

   task automatic test_convert_427();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_busy got=%b expected=0", busy);
      end
      strobe(427);
      wait_idle("latency_427", 17);
      check_display("disp_427", 427);
   endtask

   task automatic test_values();
      int vals [$];
      logic signed [15:0] r;
      vals = '{-58, 1000, -32768, 999, -999, -1000, 32767, -1, 100, 0};
      for (int i = 0; i < 8; i++) begin
         r = 16'($urandom);
         vals.push_back(int'(r));
         vals.push_back($urandom_range(0, 999) * (($urandom & 1) != 0 ? -1 : 1));
      end
      foreach (vals[i]) begin
         strobe(vals[i]);
         wait_idle("latency_val", 17);
         check_display("disp_val", vals[i]);
      end
   endtask

   task automatic test_back_to_back();
      int busy_cnt;
      bit saw5, saw7, done;
      strobe(12);
      wait_idle("latency_pre", 17);
      value_in    = 16'd5;
      value_valid = 1'b1;
      busy_cnt = 0; saw5 = 0; saw7 = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         tick();
         value_valid = 1'b0;
         if (c == 2) begin value_in = 16'd7; value_valid = 1'b1; end
         if (c == 5) begin value_in = 16'd9; value_valid = 1'b1; end
         if (busy === 1'b1) busy_cnt++;
         else done = 1;
         if (an === 4'b1110) begin
            if (seg === exp_glyph(5, 0)) saw5 = 1;
            if (seg === exp_glyph(7, 0)) saw7 = 1;
         end
      end
      n_tests++;
      if (busy_cnt != 34) begin
         n_fail++;
         $display("FAIL b2b_busy_cycles got=%0d expected=34", busy_cnt);
      end
      n_tests++;
      if (!saw5) begin
         n_fail++;
         $display("FAIL b2b_first_shown got=0 expected=1");
      end
      n_tests++;
      if (saw7) begin
         n_fail++;
         $display("FAIL b2b_overwritten_shown got=1 expected=0");
      end
      check_display("b2b_final", 9);
   endtask

   task automatic test_blink();
      int visits;
      logic [6:0] last;
      logic [3:0] prev_an;
      int k;
      strobe(427);
      wait_idle("latency_blink", 17);
      blink_on   = 1'b1;
      cursor_sel = 2'd1;
`ifdef SEG7_BLINK_EN
      visits  = 0;
      last    = 7'h00;
      prev_an = an;
      repeat (RDIV + 1) tick();
      for (int c = 0; c < 7 * 4 * RDIV; c++) begin
         tick();
         k = slot_of(an);
         if (an !== prev_an && k >= 0) begin
            n_tests++;
            if (k == 1) begin
               if (seg !== exp_glyph(427, 1) && seg !== G_BLANK) begin
                  n_fail++;
                  $display("FAIL blink_slot1 got=%b expected=%b or blank", seg, exp_glyph(427, 1));
               end else if (visits > 0 && seg === last) begin
                  n_fail++;
                  $display("FAIL blink_alternate got=%b expected!=%b", seg, last);
               end
               last = seg;
               visits++;
            end else if (seg !== exp_glyph(427, k)) begin
               n_fail++;
               $display("FAIL blink_steady slot%0d got=%b expected=%b", k, seg, exp_glyph(427, k));
            end
         end
         prev_an = an;
      end
      n_tests++;
      if (visits < 5) begin
         n_fail++;
         $display("FAIL blink_visits got=%0d expected>=5", visits);
      end
`else
      visits  = 0;
      last    = 7'h00;
      prev_an = 4'b1111;
      k       = 0;
      cursor_sel = 2'($urandom_range(0, 3));
      check_display("noblink_lit", 427);
`endif
      blink_on = 1'b0;
   endtask

   task automatic test_reset_mid();
      strobe(321);
      repeat (5) tick();
      reset = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0 || an !== 4'b1111 || seg !== G_BLANK) begin
         n_fail++;
         $display("FAIL reset_mid got busy=%b an=%b seg=%b expected 0 1111 1111111", busy, an, seg);
      end
      repeat (2) tick();
      reset = 1'b0;
      repeat (20) tick();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_busy got=%b expected=0", busy);
      end
      check_display("reset_mid_disp", 0);
   endtask

   initial begin
      dig_tab[0] = 7'b1000000; dig_tab[1] = 7'b1111001; dig_tab[2] = 7'b0100100;
      dig_tab[3] = 7'b0110000; dig_tab[4] = 7'b0011001; dig_tab[5] = 7'b0010010;
      dig_tab[6] = 7'b0000010; dig_tab[7] = 7'b1111000; dig_tab[8] = 7'b0000000;
      dig_tab[9] = 7'b0010000;
      test_reset();
      test_convert_427();
      test_values();
      test_back_to_back();
      test_blink();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
